strobe_nco: RTL

- Multi-channel phase-accumulator strobe generator, the parametrised successor to the single fixed divide-by-4 pixel-strobe divider.
- Each channel has a runtime-programmable increment, an enable and a common phase-sync clear.
- Each channel produces a one-cycle strobe and a ~50% square wave.
- Sits at top level beside the VGA timing logic and drives pixel strobe, game-tick and blink/debounce sample rates from the 100 MHz clk.

---
 rtl/strobe_nco.sv | 89 ++++++++
 1 files changed

// File: rtl/strobe_nco.sv
`default_nettype none
// ============================================================================
// Module      : strobe_nco
// Description : Multi-channel phase-accumulator strobe generator. Each
//               channel adds a programmable increment to an accumulator every
//               enabled cycle. The carry out of the accumulator becomes a
//               one-cycle strobe, and the accumulator MSB is a ~50% square
//               wave. The average strobe rate is inc / 2^ACC_W of clk.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1            system clock
//   rst       in   1            synchronous active-high reset
//   i_en      in   N_CH         per-channel run enable
//   i_sync    in   1            clears every accumulator (phase alignment)
//   i_wr_en   in   1            increment write strobe
//   i_wr_ch   in   CH_W         channel index for the write
//   i_wr_data in   ACC_W        new increment value
//   o_stb     out  N_CH         per-channel one-cycle strobe (registered carry)
//   o_sq      out  N_CH         per-channel square wave (accumulator MSB)
//   o_inc_rd  out  N_CH*ACC_W   increment registers, channel 0 at the LSBs
// ============================================================================
module strobe_nco #(
    parameter int               N_CH        = 4,
    parameter int               ACC_W       = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 16'h4000,
    parameter int               CH_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       i_en,
    input  logic                  i_sync,
    input  logic                  i_wr_en,
    input  logic [CH_W-1:0]       i_wr_ch,
    input  logic [ACC_W-1:0]      i_wr_data,
    output logic [N_CH-1:0]       o_stb,
    output logic [N_CH-1:0]       o_sq,
    output logic [N_CH*ACC_W-1:0] o_inc_rd
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] r_inc;
            logic             r_stb;
            logic [ACC_W:0]   w_sum;
            logic             w_wr_hit;

            // One extra bit so the carry out of the accumulator is the strobe.
            assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

            // Indices at or above N_CH never match any channel, so such
            // writes are dropped without a separate range check.
            assign w_wr_hit = i_wr_en && (i_wr_ch == CH_W'(i));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                    r_stb <= 1'b0;
                    r_inc <= DEFAULT_INC;
                end else begin
                    // The sum above already uses the current increment, so a
                    // write here takes effect on the next edge and leaves the
                    // phase untouched (phase-continuous retune).
                    if (w_wr_hit) begin
                        r_inc <= i_wr_data;
                    end

                    if (i_sync) begin
                        r_acc <= '0;
                        r_stb <= 1'b0;
                    end else if (i_en[i]) begin
                        {r_stb, r_acc} <= w_sum;
                    end else begin
                        // Disabled: phase holds, no strobe. Re-enabling
                        // resumes from the held phase.
                        r_stb <= 1'b0;
                    end
                end
            end

            assign o_stb[i]                    = r_stb;
            assign o_sq[i]                     = r_acc[ACC_W-1];
            assign o_inc_rd[i*ACC_W +: ACC_W]  = r_inc;
        end
    endgenerate

endmodule
`default_nettype wire
